button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
//  Debounces and synchronises a bus of raw push-button inputs into clean levels.
//  Each bit is handled independently. It sits between the board buttons and the game FSM.
//  It replaces edge-triggering on raw inputs with glitch-free levels in the clk domain.
// PARAMETERS
//  WIDTH    5          number of independent button bits
//  CNT_MAX  1_000_000  consecutive stable cycles needed to accept a change (10 ms @ 100 MHz); must be >=2
//  CNT_W    $clog2(CNT_MAX+1)  counter width; derived, do not override
// PORTS
//  clk        in   1      system clock; all logic on posedge
//  reset      in   1      synchronous, active-high reset
//  btn_in     in   WIDTH  raw asynchronous button levels (1 = pressed)
//  btn_out    out  WIDTH  debounced level per bit, registered
//  btn_rise   out  WIDTH  one-cycle pulse on each 0->1 change of btn_out (BUTTON_DEBOUNCE_PULSE_EN only)
// BEHAVIOUR
//  - Interface (fixed): one clock, clk; reset is synchronous and active-high, reset.
//  - Reset: sync stages, counters, btn_out and btn_rise all clear to 0 on the first posedge with reset=1.
//    Reset mid-count discards any partial count.
//  - Synchroniser: a 2-FF chain per bit, btn_in -> s1 -> s2. Only s2 is used downstream.
//  - Per bit, each posedge, with reset=0:
//      s2 == btn_out                    : cnt <= 0
//      s2 != btn_out, cnt <  CNT_MAX-1  : cnt <= cnt+1
//      s2 != btn_out, cnt == CNT_MAX-1  : btn_out <= s2, cnt <= 0
//  - btn_out therefore changes on the CNT_MAX-th consecutive cycle on which s2 differs from it.
//  - Latency: an input held stable from before posedge k shows in btn_out after posedge k+CNT_MAX+1.
//    That is CNT_MAX+2 edges including both sync stages.
//  - Glitch rejection: any bounce of s2 back to btn_out before the count completes clears cnt.
//    btn_out does not move.
//  - Release is symmetric with press: same count and same latency for 1->0.
//  - Bits are fully independent. Simultaneous changes on several bits each complete on their own count.
//  - Counter saturation: cnt never exceeds CNT_MAX-1 and never wraps.
//  - No combinational path from btn_in to any output.
// CONFIGURATION
//  - BUTTON_DEBOUNCE_PULSE_EN defined:
//    btn_rise port exists.
//    btn_rise[i] = 1 for exactly the single cycle after btn_out[i] goes 0->1, else 0.
//    Registered; cleared by reset.
//  - BUTTON_DEBOUNCE_PULSE_EN undefined: btn_rise port and its logic are absent. Everything else is identical.
// STRUCTURE
//  - Shared package debounce_pkg:
//    DEFAULT_WIDTH = 5 and DEFAULT_CNT_MAX = 1_000_000.
//    Button bit-position constants: UP=0, LEFT=1, RIGHT=2, DOWN=3, START=4.
//  - Sub-module debounce_cell: one bit.
//    Holds the sync FFs, the counter, the output flop and the optional rise flop.
//  - The top level instantiates WIDTH cells in a generate loop.
// TESTING  (run with CNT_MAX=4, WIDTH=5)
//  1 reset=1 for 2 cycles with btn_in=5'b11111
//    -> btn_out=0 (and btn_rise=0) during reset and on the cycle after release.
//  2 btn_in 0->5'b00001 held
//    -> btn_out[0] rises exactly 6 posedges after the first sampling edge; other bits stay 0.
//  3 btn_in[1] pulses high for 3 cycles, then low
//    -> btn_out stays 5'b00000 (glitch rejected).
//  4 btn_in[4] bounces 1,0,1,1,1,1,1 cycle-by-cycle
//    -> btn_out[4] rises only after 4 consecutive high samples at s2.
//  5 btn_out=5'b01000, then btn_in=0 held -> btn_out[3] falls after 6 edges.
//    With PULSE_EN: btn_rise[3] high for exactly 1 cycle on the earlier rise, no pulse on the fall.
//  6 btn_in=5'b10110 while a count is in progress, reset asserted for 1 cycle
//    -> counts cleared; btn_out=0; full 6-edge latency restarts.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared constants for the push-button debouncer and its users.
//   DEFAULT_WIDTH / DEFAULT_CNT_MAX : default parameter values for button_debounce.
//   UP/LEFT/RIGHT/DOWN/START        : bit positions of each button in the btn_* buses.
package debounce_pkg;

  localparam int DEFAULT_WIDTH   = 5;
  localparam int DEFAULT_CNT_MAX = 1_000_000;

  localparam int UP    = 0;
  localparam int LEFT  = 1;
  localparam int RIGHT = 2;
  localparam int DOWN  = 3;
  localparam int START = 4;

endpackage

// File: rtl/debounce_cell.sv
// debounce_cell
//   Single-bit debouncer: 2-FF synchroniser followed by a stability counter.
//   btn_out only follows the synchronised input after it has differed from
//   btn_out for CNT_MAX consecutive cycles; any bounce back clears the count.
//   Optional macro BUTTON_DEBOUNCE_PULSE_EN adds btn_rise, a registered
//   one-cycle pulse coincident with the first cycle btn_out reads 1.
// Ports
//   clk      in   system clock, posedge
//   reset    in   synchronous, active-high
//   btn_in   in   raw asynchronous button level
//   btn_out  out  debounced level, registered
//   btn_rise out  rise pulse (BUTTON_DEBOUNCE_PULSE_EN only)
module debounce_cell #(
  parameter int CNT_MAX = 4,
  parameter int CNT_W   = $clog2(CNT_MAX + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_out
`ifdef BUTTON_DEBOUNCE_PULSE_EN
  ,
  output logic btn_rise
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             done;

  assign differ = (s2 != btn_out);
  // Count completes on the CNT_MAX-th consecutive differing cycle.
  assign done   = differ && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      cnt     <= '0;
      btn_out <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
      if (!differ) begin
        cnt <= '0;
      end else if (done) begin
        btn_out <= s2;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

`ifdef BUTTON_DEBOUNCE_PULSE_EN
  // Set on the same edge that moves btn_out 0->1, so the pulse lines up
  // with the first high cycle of btn_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_rise <= 1'b0;
    end else begin
      btn_rise <= done && s2;
    end
  end
`endif

endmodule

// File: rtl/button_debounce.sv
// button_debounce
//   Debounces and synchronises a bus of raw push-button inputs into clean
//   levels in the clk domain; one independent debounce_cell per bit.
//   Optional macro BUTTON_DEBOUNCE_PULSE_EN adds the btn_rise output.
// Ports
//   clk      in   system clock, posedge
//   reset    in   synchronous, active-high
//   btn_in   in   [WIDTH] raw asynchronous button levels (1 = pressed)
//   btn_out  out  [WIDTH] debounced levels, registered
//   btn_rise out  [WIDTH] one-cycle 0->1 pulses (BUTTON_DEBOUNCE_PULSE_EN only)
module button_debounce
  import debounce_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int CNT_MAX = DEFAULT_CNT_MAX,
  parameter int CNT_W   = $clog2(CNT_MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_out
`ifdef BUTTON_DEBOUNCE_PULSE_EN
  ,
  output logic [WIDTH-1:0] btn_rise
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    debounce_cell #(
      .CNT_MAX (CNT_MAX),
      .CNT_W   (CNT_W)
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .btn_in   (btn_in[i]),
      .btn_out  (btn_out[i])
`ifdef BUTTON_DEBOUNCE_PULSE_EN
      ,
      .btn_rise (btn_rise[i])
`endif
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;
  import debounce_pkg::*;

  localparam int WIDTH   = 5;
  localparam int CNT_MAX = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] btn_in;
  logic [WIDTH-1:0] btn_out;
  logic [WIDTH-1:0] btn_rise;

  int tests_run;
  int tests_failed;

  button_debounce #(
    .WIDTH   (WIDTH),
    .CNT_MAX (CNT_MAX)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .btn_out  (btn_out)
`ifdef BUTTON_DEBOUNCE_PULSE_EN
    ,
    .btn_rise (btn_rise)
`endif
  );

`ifndef BUTTON_DEBOUNCE_PULSE_EN
  assign btn_rise = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one posedge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn_in = '0;
    reset  = 1'b1;
    tick();
    tick();
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    btn_in = 5'b11111;
    reset  = 1'b1;
    for (int t = 1; t <= 2; t++) begin
      tick();
      tests_run++;
      if (btn_out !== 5'b00000) begin
        tests_failed++;
        $display("FAIL reset_out t=%0d actual=%b expected=%b", t, btn_out, 5'b00000);
      end
`ifdef BUTTON_DEBOUNCE_PULSE_EN
      tests_run++;
      if (btn_rise !== 5'b00000) begin
        tests_failed++;
        $display("FAIL reset_rise t=%0d actual=%b expected=%b", t, btn_rise, 5'b00000);
      end
`endif
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if (btn_out !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_release_out actual=%b expected=%b", btn_out, 5'b00000);
    end
  endtask

  task automatic test_press();
    logic [WIDTH-1:0] exp_out;
    logic [WIDTH-1:0] exp_rise;
    do_reset();
    btn_in = 5'b00001;
    for (int t = 1; t <= 10; t++) begin
      tick();
      exp_out  = (t >= 6) ? 5'b00001 : 5'b00000;
      exp_rise = (t == 6) ? 5'b00001 : 5'b00000;
      tests_run++;
      if (btn_out !== exp_out) begin
        tests_failed++;
        $display("FAIL press_out t=%0d actual=%b expected=%b", t, btn_out, exp_out);
      end
`ifdef BUTTON_DEBOUNCE_PULSE_EN
      tests_run++;
      if (btn_rise !== exp_rise) begin
        tests_failed++;
        $display("FAIL press_rise t=%0d actual=%b expected=%b", t, btn_rise, exp_rise);
      end
`endif
    end
  endtask

  task automatic test_glitch();
    do_reset();
    btn_in = '0;
    btn_in[LEFT] = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      tests_run++;
      if (btn_out !== 5'b00000) begin
        tests_failed++;
        $display("FAIL glitch_out t=%0d actual=%b expected=%b", t, btn_out, 5'b00000);
      end
      if (t == 3) btn_in = '0;
    end
  endtask

  task automatic test_bounce();
    logic [6:0]       pat;
    logic [WIDTH-1:0] exp_out;
    pat = 7'b1111101;  // pat[0] applied first: 1,0,1,1,1,1,1
    do_reset();
    for (int t = 0; t < 11; t++) begin
      btn_in = '0;
      btn_in[START] = (t < 7) ? pat[t] : 1'b1;
      tick();
      exp_out = ((t + 1) >= 8) ? 5'b10000 : 5'b00000;
      tests_run++;
      if (btn_out !== exp_out) begin
        tests_failed++;
        $display("FAIL bounce_out t=%0d actual=%b expected=%b", t + 1, btn_out, exp_out);
      end
    end
  endtask

  task automatic test_release();
    logic [WIDTH-1:0] exp_out;
    logic [WIDTH-1:0] exp_rise;
    do_reset();
    btn_in = '0;
    btn_in[DOWN] = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp_out  = (t >= 6) ? 5'b01000 : 5'b00000;
      exp_rise = (t == 6) ? 5'b01000 : 5'b00000;
      tests_run++;
      if (btn_out !== exp_out) begin
        tests_failed++;
        $display("FAIL release_press_out t=%0d actual=%b expected=%b", t, btn_out, exp_out);
      end
`ifdef BUTTON_DEBOUNCE_PULSE_EN
      tests_run++;
      if (btn_rise !== exp_rise) begin
        tests_failed++;
        $display("FAIL release_press_rise t=%0d actual=%b expected=%b", t, btn_rise, exp_rise);
      end
`endif
    end
    btn_in = '0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp_out = (t >= 6) ? 5'b00000 : 5'b01000;
      tests_run++;
      if (btn_out !== exp_out) begin
        tests_failed++;
        $display("FAIL release_out t=%0d actual=%b expected=%b", t, btn_out, exp_out);
      end
`ifdef BUTTON_DEBOUNCE_PULSE_EN
      tests_run++;
      if (btn_rise !== 5'b00000) begin
        tests_failed++;
        $display("FAIL release_rise t=%0d actual=%b expected=%b", t, btn_rise, 5'b00000);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] exp_out;
    logic [WIDTH-1:0] exp_rise;
    do_reset();
    btn_in = 5'b10110;
    for (int t = 1; t <= 3; t++) begin
      tick();
      tests_run++;
      if (btn_out !== 5'b00000) begin
        tests_failed++;
        $display("FAIL midreset_pre t=%0d actual=%b expected=%b", t, btn_out, 5'b00000);
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (btn_out !== 5'b00000) begin
      tests_failed++;
      $display("FAIL midreset_during actual=%b expected=%b", btn_out, 5'b00000);
    end
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp_out  = (t >= 6) ? 5'b10110 : 5'b00000;
      exp_rise = (t == 6) ? 5'b10110 : 5'b00000;
      tests_run++;
      if (btn_out !== exp_out) begin
        tests_failed++;
        $display("FAIL midreset_out t=%0d actual=%b expected=%b", t, btn_out, exp_out);
      end
`ifdef BUTTON_DEBOUNCE_PULSE_EN
      tests_run++;
      if (btn_rise !== exp_rise) begin
        tests_failed++;
        $display("FAIL midreset_rise t=%0d actual=%b expected=%b", t, btn_rise, exp_rise);
      end
`endif
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    btn_in       = '0;
    test_reset();
    test_press();
    test_glitch();
    test_bounce();
    test_release();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
